ysyx_22041461_lsu: RTL and testbench
====================================

Name: ysyx_22041461_lsu

Overview:
- Memory-access stage directly downstream of the execute stage. It accepts one instruction per handshake: ALU result, store data, rd and memory-control code.
- Loads and stores perform one 64-bit aligned-bus transaction with byte strobes. Loads are sign- or zero-extended; stores shift the data into the addressed lanes.
- Results go to writeback through a registered valid/ready output. Non-memory instructions pass through with one cycle of latency.

Parameters:
- XLEN, 64, data/address width (the only supported value).
- TIMEOUT, 0, reserved. Must be 0; no timeout logic.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute stage presents an instruction
- in_ready  out  1  this stage accepts it this cycle
- in_alu  in  64  ALU result; also the effective address for memory ops
- in_wdata  in  64  store data (rs2 value)
- in_rd  in  5  destination register
- in_wen  in  1  register write request for non-memory ops
- in_ctrl_mem  in  4  0 none; 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU; 8 SB, 9 SH, 10 SW, 11 SD; 12-15 treated as none
- in_pc  in  64  instruction PC, passed through
- mem_req  out  1  bus request
- mem_we  out  1  1 = store
- mem_addr  out  64  {in_alu[63:3], 3'b0}
- mem_wstrb  out  8  byte strobes
- mem_wdata  out  64  lane-shifted store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  64  load data (full aligned doubleword)
- out_valid  out  1  result available to writeback
- out_ready  in  1  writeback consumes it
- out_rd  out  5  destination register
- out_wen  out  1  register write enable
- out_data  out  64  writeback value
- out_pc  out  64  PC
- out_misalign  out  1  the memory access was misaligned and was suppressed

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM returns to IDLE.
  - out_valid, mem_req, mem_we, out_wen and out_misalign = 0.
  - mem_wstrb = 0; all data, address and PC registers = 0.
  - Reset mid-transaction drops mem_req immediately. Any later gnt or rvalid is ignored until a new request is issued.
- FSM states: IDLE, REQ, WAIT_R, OUT.
- in_ready = (state==IDLE) && !out_valid. Accept happens when in_valid && in_ready.
- On accept from IDLE:
  - ctrl none → latch rd/wen/alu/pc and go to OUT; out_valid=1 next cycle, out_data=in_alu.
  - Misaligned → go to OUT with out_misalign=1, out_wen=0, and no bus request. Misaligned means: LH/LHU/SH with addr[0]≠0; LW/LWU/SW with addr[1:0]≠0; LD/SD with addr[2:0]≠0.
  - Otherwise → latch the operation and go to REQ.
- REQ:
  - mem_req=1; address, we, wstrb and wdata are held stable until gnt.
  - Strobe base is 8'h01/03/0F/FF for B/H/W/D, shifted left by addr[2:0].
  - mem_wdata = in_wdata << (8*addr[2:0]).
  - On gnt: a store goes to OUT with out_wen=0; a load goes to WAIT_R.
  - rvalid sampled in REQ is ignored.
- WAIT_R:
  - On rvalid: take mem_rdata >> (8*addr[2:0]), truncate to the access size, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU/LD). Result goes to out_data with out_wen = latched wen; go to OUT.
  - rvalid arrives no earlier than the cycle after gnt.
- OUT:
  - out_valid=1; all out_* outputs are held stable while out_ready=0.
  - When out_ready=1: out_valid drops next cycle and the FSM returns to IDLE.
  - A new instruction is not accepted in the same cycle as out_ready (no overlap).
- Stores always drive out_wen=0 regardless of in_wen. A load to rd=0 keeps out_wen as latched; writeback discards x0.
- Minimum latency from accept to out_valid: non-memory 1 cycle; store 2 cycles (gnt in the first REQ cycle); load 3 cycles.
- out_misalign clears when the next result is presented.

Test Plan:
- ALU pass-through: ctrl=0, alu=0x1234, rd=5, wen=1, out_ready=1 → out_valid one cycle after accept, out_data=0x1234, out_wen=1, no mem_req.
- LB sign extend: alu=0x80000003, rdata=0x00000000_AB000000, gnt immediate, rvalid next cycle → mem_addr=0x80000000, out_data=0xFFFFFFFF_FFFFFFAB, out_valid at accept+3.
- LHU/LWU zero extend: LHU at 0x80000006 with rdata=0xBEEF0000_00000000 → out_data=0xBEEF. LWU at 0x80000004 with rdata=0x89ABCDEF_00000000 → out_data=0x89ABCDEF.
- SH store: alu=0x80000002, wdata=0xCAFE, gnt delayed 3 cycles → mem_req held 4 cycles with mem_wstrb=8'h0C and mem_wdata=0x00000000_CAFE0000; then out_valid with out_wen=0.
- Misaligned LW at 0x80000001 → no mem_req, out_misalign=1, out_wen=0; next aligned op clears out_misalign.
- Back-pressure and reset:
  - out_ready=0 for 5 cycles → out_* stable and in_ready=0 throughout.
  - rst_n pulled low while in WAIT_R → mem_req and out_valid go to 0 at once; a stale rvalid after reset produces no output.

Source files
------------

// File: rtl/ysyx_22041461_lsu.sv
// ysyx_22041461_lsu -- memory-access stage between execute and writeback.
//
// Accepts one instruction per in_valid/in_ready handshake. Non-memory ops
// pass to the output register after one cycle. Aligned loads/stores issue a
// single 64-bit aligned bus transaction with byte strobes; misaligned memory
// ops are suppressed and flagged. Results are held on out_* until out_ready.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               execute-stage handshake
//   in_alu, in_wdata, in_rd,        ALU result / effective address, store data,
//   in_wen, in_ctrl_mem, in_pc      rd, write request, memory op code, PC
//   mem_req/mem_we/mem_addr/        bus request (held until mem_gnt), store flag,
//   mem_wstrb/mem_wdata             aligned address, byte strobes, lane data
//   mem_gnt, mem_rvalid, mem_rdata  bus grant, load data valid, load data
//   out_valid/out_ready             writeback handshake
//   out_rd, out_wen, out_data,      writeback destination, enable, value,
//   out_pc, out_misalign            PC, suppressed-misaligned-access flag
module ysyx_22041461_lsu #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    input  logic [3:0]      in_ctrl_mem,
    input  logic [XLEN-1:0] in_pc,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [7:0]      mem_wstrb,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic            out_wen,
    output logic [XLEN-1:0] out_data,
    output logic [XLEN-1:0] out_pc,
    output logic            out_misalign
);

    // No timeout logic exists; only TIMEOUT == 0 is meaningful.
    if (TIMEOUT != 0) begin : g_timeout_unsupported
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_R,
        S_OUT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [7:0]      wstrb_q, wstrb_d;
    logic [4:0]      rd_q, rd_d;
    logic [3:0]      op_q, op_d;
    logic            wen_q, wen_d;
    logic            out_wen_q, out_wen_d;
    logic            misalign_q, misalign_d;

    // Decode of the incoming op code.
    logic            in_is_load, in_is_store, in_is_mem, in_misalign;
    logic [7:0]      in_strb_base;
    logic [XLEN-1:0] rd_shifted;
    logic [XLEN-1:0] load_value;
    logic            op_is_store;

    always_comb begin
        in_is_load   = (in_ctrl_mem >= 4'd1) && (in_ctrl_mem <= 4'd7);
        in_is_store  = (in_ctrl_mem >= 4'd8) && (in_ctrl_mem <= 4'd11);
        in_is_mem    = in_is_load || in_is_store;
        in_strb_base = 8'h00;
        in_misalign  = 1'b0;
        case (in_ctrl_mem)
            4'd1, 4'd5, 4'd8: in_strb_base = 8'h01;
            4'd2, 4'd6, 4'd9: begin
                in_strb_base = 8'h03;
                in_misalign  = in_alu[0];
            end
            4'd3, 4'd7, 4'd10: begin
                in_strb_base = 8'h0F;
                in_misalign  = |in_alu[1:0];
            end
            4'd4, 4'd11: begin
                in_strb_base = 8'hFF;
                in_misalign  = |in_alu[2:0];
            end
            default: ;
        endcase
    end

    assign op_is_store = (op_q >= 4'd8) && (op_q <= 4'd11);

    // Load data: move the addressed lane down to bit 0, then size/extend.
    always_comb begin
        rd_shifted = mem_rdata >> {addr_q[2:0], 3'b000};
        load_value = rd_shifted;
        case (op_q)
            4'd1:    load_value = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
            4'd2:    load_value = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
            4'd3:    load_value = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
            4'd5:    load_value = {56'd0, rd_shifted[7:0]};
            4'd6:    load_value = {48'd0, rd_shifted[15:0]};
            4'd7:    load_value = {32'd0, rd_shifted[31:0]};
            default: load_value = rd_shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pc_d       = pc_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        wstrb_d    = wstrb_q;
        rd_d       = rd_q;
        op_d       = op_q;
        wen_d      = wen_q;
        out_wen_d  = out_wen_q;
        misalign_d = misalign_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rd_d   = in_rd;
                    wen_d  = in_wen;
                    addr_d = in_alu;
                    pc_d   = in_pc;
                    op_d   = in_ctrl_mem;
                    if (!in_is_mem) begin
                        data_d     = in_alu;
                        out_wen_d  = in_wen;
                        misalign_d = 1'b0;
                        state_d    = S_OUT;
                    end else if (in_misalign) begin
                        data_d     = in_alu;
                        out_wen_d  = 1'b0;
                        misalign_d = 1'b1;
                        state_d    = S_OUT;
                    end else begin
                        wstrb_d = in_strb_base << in_alu[2:0];
                        wdata_d = in_wdata << {in_alu[2:0], 3'b000};
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    if (op_is_store) begin
                        data_d     = addr_q;
                        out_wen_d  = 1'b0;
                        misalign_d = 1'b0;
                        state_d    = S_OUT;
                    end else begin
                        state_d = S_WAIT_R;
                    end
                end
            end
            S_WAIT_R: begin
                if (mem_rvalid) begin
                    data_d     = load_value;
                    out_wen_d  = wen_q;
                    misalign_d = 1'b0;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            pc_q       <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            wstrb_q    <= '0;
            rd_q       <= '0;
            op_q       <= '0;
            wen_q      <= 1'b0;
            out_wen_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pc_q       <= pc_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            wstrb_q    <= wstrb_d;
            rd_q       <= rd_d;
            op_q       <= op_d;
            wen_q      <= wen_d;
            out_wen_q  <= out_wen_d;
            misalign_q <= misalign_d;
        end
    end

    assign out_valid    = (state_q == S_OUT);
    assign in_ready     = (state_q == S_IDLE) && !out_valid;
    assign mem_req      = (state_q == S_REQ);
    assign mem_we       = mem_req && op_is_store;
    assign mem_addr     = {addr_q[XLEN-1:3], 3'b000};
    assign mem_wstrb    = wstrb_q;
    assign mem_wdata    = wdata_q;
    assign out_rd       = rd_q;
    assign out_wen      = out_wen_q;
    assign out_data     = data_q;
    assign out_pc       = pc_q;
    assign out_misalign = misalign_q;

endmodule

// File: tb/tb_ysyx_22041461_lsu.sv
module tb_ysyx_22041461_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_alu, in_wdata, in_pc;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [3:0]  in_ctrl_mem;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [63:0] out_data, out_pc;
    logic        out_misalign;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    ysyx_22041461_lsu #(.XLEN(64), .TIMEOUT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu(in_alu), .in_wdata(in_wdata), .in_rd(in_rd), .in_wen(in_wen),
        .in_ctrl_mem(in_ctrl_mem), .in_pc(in_pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_wen(out_wen), .out_data(out_data), .out_pc(out_pc),
        .out_misalign(out_misalign)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes, 0 for non-memory codes.
    function automatic int unsigned m_size(input logic [3:0] c);
        case (c)
            4'd1, 4'd5, 4'd8:  return 1;
            4'd2, 4'd6, 4'd9:  return 2;
            4'd3, 4'd7, 4'd10: return 4;
            4'd4, 4'd11:       return 8;
            default:           return 0;
        endcase
    endfunction

    function automatic bit m_is_store(input logic [3:0] c);
        return (c >= 4'd8) && (c <= 4'd11);
    endfunction

    function automatic bit m_misaligned(input logic [3:0] c, input logic [63:0] a);
        int unsigned n = m_size(c);
        return (n != 0) && ((a % n) != 0);
    endfunction

    function automatic logic [63:0] m_load(input logic [3:0] c, input logic [63:0] a,
                                           input logic [63:0] rdata);
        int unsigned n   = m_size(c);
        int unsigned off = int'(a % 8);
        logic [63:0] v, mask;
        v = rdata >> (8 * off);
        if (n < 8) begin
            mask = (64'd1 << (8 * n)) - 64'd1;
            v    = v & mask;
            if (c >= 4'd1 && c <= 4'd3 && v[8*n-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic logic [7:0] m_strb(input logic [3:0] c, input logic [63:0] a);
        logic [15:0] s;
        s = ((16'd1 << m_size(c)) - 16'd1) << (a % 8);
        return s[7:0];
    endfunction

    // One complete instruction. Entered and left at a negedge.
    task automatic do_op(input logic [3:0] c, input logic [63:0] alu, input logic [63:0] wdata,
                         input logic [63:0] rdata, input logic [4:0] rd, input logic wen,
                         input int unsigned gd, input int unsigned rdly, input int unsigned bp);
        logic [63:0] pc = {$urandom, $urandom};
        bit          mem = (m_size(c) != 0);
        bit          mis = m_misaligned(c, alu);
        bit          st  = m_is_store(c);
        logic [63:0] exp_data;
        logic [63:0] hold;

        chk("in_ready_idle", in_ready, 1);
        in_valid = 1; in_ctrl_mem = c; in_alu = alu; in_wdata = wdata;
        in_rd = rd; in_wen = wen; in_pc = pc;
        @(posedge clk); @(negedge clk);
        in_valid = 0; in_ctrl_mem = $urandom; in_alu = {$urandom, $urandom};

        if (mem && !mis) begin
            for (int unsigned i = 0; i <= gd; i++) begin
                chk("req_held", mem_req, 1);
                chk("req_we", mem_we, st);
                chk("req_addr", mem_addr, alu & ~64'h7);
                chk("req_strb", mem_wstrb, m_strb(c, alu));
                if (st) chk("req_wdata", mem_wdata, wdata << (8 * (alu % 8)));
                chk("req_no_out", out_valid, 0);
                mem_gnt    = (i == gd);
                mem_rvalid = $urandom_range(0, 1);
                mem_rdata  = {$urandom, $urandom};
                @(posedge clk); @(negedge clk);
                mem_gnt = 0; mem_rvalid = 0;
            end
            if (!st) begin
                for (int unsigned j = 0; j <= rdly; j++) begin
                    chk("wait_no_req", mem_req, 0);
                    chk("wait_no_out", out_valid, 0);
                    mem_rvalid = (j == rdly);
                    mem_rdata  = (j == rdly) ? rdata : {$urandom, $urandom};
                    @(posedge clk); @(negedge clk);
                    mem_rvalid = 0;
                end
            end
        end

        if (!mem)      exp_data = alu;
        else if (!st)  exp_data = m_load(c, alu, rdata);
        else           exp_data = 'x;

        chk("out_valid", out_valid, 1);
        chk("out_rd", out_rd, rd);
        chk("out_pc", out_pc, pc);
        chk("out_wen", out_wen, (!mem) ? wen : (mis || st) ? 1'b0 : wen);
        chk("out_misalign", out_misalign, mem && mis);
        chk("out_no_req", mem_req, 0);
        chk("out_in_ready", in_ready, 0);
        if (!mis && !st) chk("out_data", out_data, exp_data);
        hold = out_data;

        for (int unsigned k = 0; k < bp; k++) begin
            out_ready = 0;
            @(posedge clk); @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, hold);
            chk("bp_in_ready", in_ready, 0);
        end

        // Offer a new instruction together with out_ready: must not be taken.
        out_ready = 1; in_valid = 1; in_ctrl_mem = 4'd0;
        @(posedge clk); @(negedge clk);
        out_ready = 0; in_valid = 0;
        chk("drain_valid", out_valid, 0);
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_alu = '0; in_wdata = '0; in_pc = '0;
        in_rd = '0; in_wen = 0; in_ctrl_mem = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; out_ready = 0;

        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_out_wen", out_wen, 0);
        chk("rst_misalign", out_misalign, 0);
        chk("rst_wstrb", mem_wstrb, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_out_pc", out_pc, 0);
        rst_n = 1;
        @(negedge clk);

        // Directed cases.
        do_op(4'd0, 64'h1234, 64'h0, 64'h0, 5'd5, 1'b1, 0, 0, 0);
        do_op(4'd1, 64'h8000_0003, 64'h0, 64'h0000_0000_AB00_0000, 5'd7, 1'b1, 0, 0, 0);
        chk("lb_model", m_load(4'd1, 64'h8000_0003, 64'hAB00_0000), 64'hFFFF_FFFF_FFFF_FFAB);
        do_op(4'd6, 64'h8000_0006, 64'h0, 64'hBEEF_0000_0000_0000, 5'd8, 1'b1, 0, 1, 0);
        do_op(4'd7, 64'h8000_0004, 64'h0, 64'h89AB_CDEF_0000_0000, 5'd9, 1'b1, 1, 0, 0);
        do_op(4'd9, 64'h8000_0002, 64'hCAFE, 64'h0, 5'd3, 1'b1, 3, 0, 0);
        do_op(4'd3, 64'h8000_0001, 64'h0, 64'h0, 5'd4, 1'b1, 0, 0, 0);
        do_op(4'd4, 64'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd0, 1'b1, 0, 0, 0);
        do_op(4'd0, 64'h5555, 64'h0, 64'h0, 5'd1, 1'b1, 0, 0, 5);
        do_op(4'd13, 64'h7777, 64'h0, 64'h0, 5'd2, 1'b0, 0, 0, 0);

        // Randomized mix of ops, offsets, bus delays and back-pressure.
        for (int n = 0; n < 60; n++) begin
            do_op(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset while the request is outstanding.
        in_valid = 1; in_ctrl_mem = 4'd4; in_alu = 64'h1000; in_rd = 5'd6; in_wen = 1;
        @(posedge clk); @(negedge clk);
        in_valid = 0;
        chk("rstreq_pre", mem_req, 1);
        #1 rst_n = 0;
        #1;
        chk("rstreq_req", mem_req, 0);
        chk("rstreq_valid", out_valid, 0);
        chk("rstreq_strb", mem_wstrb, 0);
        chk("rstreq_addr", mem_addr, 0);
        @(negedge clk); rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            mem_gnt = 1; mem_rvalid = 1; mem_rdata = {$urandom, $urandom};
            @(posedge clk); @(negedge clk);
            chk("rstreq_stale_valid", out_valid, 0);
            chk("rstreq_stale_req", mem_req, 0);
        end
        mem_gnt = 0; mem_rvalid = 0;

        // Reset while waiting for load data.
        in_valid = 1; in_ctrl_mem = 4'd3; in_alu = 64'h2000; in_rd = 5'd6; in_wen = 1;
        @(posedge clk); @(negedge clk);
        in_valid = 0; mem_gnt = 1;
        @(posedge clk); @(negedge clk);
        mem_gnt = 0;
        chk("rstwait_pre_req", mem_req, 0);
        chk("rstwait_pre_valid", out_valid, 0);
        #1 rst_n = 0;
        #1;
        chk("rstwait_valid", out_valid, 0);
        chk("rstwait_req", mem_req, 0);
        chk("rstwait_data", out_data, 0);
        @(negedge clk); rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1; mem_rdata = {$urandom, $urandom};
            @(posedge clk); @(negedge clk);
            chk("rstwait_stale_valid", out_valid, 0);
        end
        mem_rvalid = 0;
        chk("rstwait_in_ready", in_ready, 1);

        // Normal operation resumes after reset.
        do_op(4'd5, 64'h3007, 64'h0, 64'h8100_0000_0000_0000, 5'd10, 1'b1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
